// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: word width, NOP
// encoding, PC increment, default reset PC and the IF/ID record layout.
package fetch_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // Encoding written into IF/ID when a fetched instruction is squashed.
  localparam word_t NOP_INST = 32'h0000_0000;

  // Sequential PC step (one 32-bit instruction).
  localparam word_t PC_INC = 32'd4;

  // PC loaded on reset unless the instantiating design overrides it.
  localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;

  // Source selected for the next PC value when not in reset.
  typedef enum logic [1:0] {
    PC_SEL_HOLD   = 2'd0,
    PC_SEL_BRANCH = 2'd1,
    PC_SEL_SEQ    = 2'd2
  } pc_sel_e;

  // Contents of the IF/ID pipeline register.
  typedef struct packed {
    word_t inst;
    word_t pc_plus_4;
    logic  valid;
  } ifid_t;

  localparam ifid_t IFID_RESET = '{inst: NOP_INST, pc_plus_4: '0, valid: 1'b0};

  // Force a branch target onto a word boundary; the low two bits are dropped.
  function automatic word_t align_word(input word_t addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter register with the next-PC priority mux:
// reset, then stall hold, then taken-branch redirect, then PC+4.
module fetch_pc
  import fetch_pkg::*;
#(
  parameter word_t RESET_PC = DEFAULT_RESET_PC
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  PCWrite,
  input  logic  redirect,
  input  word_t BranchAddr,
  output word_t pc,
  output word_t pc_plus_4
);

  word_t   pc_reg;
  word_t   pc_next;
  word_t   target;
  pc_sel_e pc_sel;

  // Sequential successor; 32-bit addition wraps FFFF_FFFC to 0 naturally.
  assign pc_plus_4 = pc_reg + PC_INC;

  // Branch target with the byte-offset bits discarded.
  assign target = align_word(BranchAddr);

  // Choose the PC source; a stall outranks a redirect so the branch is
  // re-evaluated once the hazard clears.
  always_comb begin
    pc_sel = PC_SEL_SEQ;
    if (!PCWrite) begin
      pc_sel = PC_SEL_HOLD;
    end else if (redirect) begin
      pc_sel = PC_SEL_BRANCH;
    end
  end

  // Next-PC mux driven by the selected source.
  always_comb begin
    pc_next = pc_plus_4;
    case (pc_sel)
      PC_SEL_HOLD:   pc_next = pc_reg;
      PC_SEL_BRANCH: pc_next = target;
      PC_SEL_SEQ:    pc_next = pc_plus_4;
      default:       pc_next = pc_plus_4;
    endcase
  end

  // PC register; reset overrides every other input on the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

  assign pc = pc_reg;

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: drives instruction memory from the PC, captures
// the returned word into the IF/ID register, squashes the wrong-path fetch
// on a taken branch, and counts fetched instructions and stall cycles.
module fetch
  import fetch_pkg::*;
#(
  parameter word_t RESET_PC = DEFAULT_RESET_PC
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  PCWrite,
  input  logic  IFIDWrite,
  input  word_t BranchAddr,
  input  logic  brunch_taken,
  input  logic  brunch_control,
  output word_t imem_addr,
  input  word_t imem_data,
  output word_t IDpc_plus_4,
  output word_t IDinst,
  output logic  IDvalid,
  output word_t fetch_count,
  output word_t stall_count
);

  word_t pc;
  word_t pc_plus_4;
  logic  redirect;
  logic  take_redirect;
  logic  ifid_load;
  ifid_t ifid_reg;
  ifid_t ifid_next;
  word_t fetch_count_reg;
  word_t stall_count_reg;

  // Branch in decode whose operands compared equal.
  assign redirect = brunch_control & brunch_taken;

  // A stalled PC suppresses the redirect and its flush for this cycle.
  assign take_redirect = redirect & PCWrite;

  fetch_pc #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clock      (clock),
    .reset      (reset),
    .PCWrite    (PCWrite),
    .redirect   (redirect),
    .BranchAddr (BranchAddr),
    .pc         (pc),
    .pc_plus_4  (pc_plus_4)
  );

  // Instruction memory is addressed straight from the PC register.
  assign imem_addr = pc;

  // A real instruction enters IF/ID only when it is written and not squashed.
  assign ifid_load = IFIDWrite & ~take_redirect;

  // IF/ID next value: hold when frozen, NOP bubble on redirect, else capture.
  always_comb begin
    ifid_next = ifid_reg;
    if (IFIDWrite) begin
      if (take_redirect) begin
        ifid_next.inst      = NOP_INST;
        ifid_next.pc_plus_4 = pc_plus_4;
        ifid_next.valid     = 1'b0;
      end else begin
        ifid_next.inst      = imem_data;
        ifid_next.pc_plus_4 = pc_plus_4;
        ifid_next.valid     = 1'b1;
      end
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clock) begin
    if (reset) begin
      ifid_reg <= IFID_RESET;
    end else begin
      ifid_reg <= ifid_next;
    end
  end

  // Count instructions that entered IF/ID as valid; wraps at 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_count_reg <= '0;
    end else if (ifid_load) begin
      fetch_count_reg <= fetch_count_reg + 32'd1;
    end
  end

  // Count cycles in which the PC was frozen; wraps at 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count_reg <= '0;
    end else if (!PCWrite) begin
      stall_count_reg <= stall_count_reg + 32'd1;
    end
  end

  assign IDinst      = ifid_reg.inst;
  assign IDpc_plus_4 = ifid_reg.pc_plus_4;
  assign IDvalid     = ifid_reg.valid;
  assign fetch_count = fetch_count_reg;
  assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for the fetch stage. Instruction memory returns
// addr + 32'h100. Expected results are queued as each cycle's stimulus is
// driven and popped after the following rising edge.
module tb_fetch;

  logic        clock;
  logic        reset;
  logic        PCWrite;
  logic        IFIDWrite;
  logic [31:0] BranchAddr;
  logic        brunch_taken;
  logic        brunch_control;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] IDpc_plus_4;
  logic [31:0] IDinst;
  logic        IDvalid;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  int checks;
  int errors;

  fetch #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .PCWrite        (PCWrite),
    .IFIDWrite      (IFIDWrite),
    .BranchAddr     (BranchAddr),
    .brunch_taken   (brunch_taken),
    .brunch_control (brunch_control),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .IDpc_plus_4    (IDpc_plus_4),
    .IDinst         (IDinst),
    .IDvalid        (IDvalid),
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
  );

  assign imem_data = imem_addr + 32'h100;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] fc;
    logic [31:0] sc;
  } exp_t;

  typedef struct {
    string       name;
    logic        rst;
    logic        pcw;
    logic        ifw;
    logic        br;
    logic [31:0] baddr;
    exp_t        exp;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[19];

  function automatic vec_t mk(input string name, input logic rst, input logic pcw,
                              input logic ifw, input logic br, input logic [31:0] baddr,
                              input logic [31:0] pc, input logic [31:0] inst,
                              input logic [31:0] pc4, input logic valid,
                              input logic [31:0] fc, input logic [31:0] sc);
    vec_t v;
    v.name = name; v.rst = rst; v.pcw = pcw; v.ifw = ifw; v.br = br; v.baddr = baddr;
    v.exp.pc = pc; v.exp.inst = inst; v.exp.pc4 = pc4; v.exp.valid = valid;
    v.exp.fc = fc; v.exp.sc = sc;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Drive one cycle, queue its expectation, then compare after the edge.
  task automatic step(input string name, input logic rst, input logic pcw, input logic ifw,
                      input logic br, input logic [31:0] baddr, input exp_t e);
    exp_t got;
    reset          = rst;
    PCWrite        = pcw;
    IFIDWrite      = ifw;
    brunch_control = br;
    brunch_taken   = br;
    BranchAddr     = baddr;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    got = exp_q.pop_front();
    cmp({name, ".pc"},    imem_addr,   got.pc);
    cmp({name, ".inst"},  IDinst,      got.inst);
    cmp({name, ".pc4"},   IDpc_plus_4, got.pc4);
    cmp({name, ".valid"}, {31'd0, IDvalid}, {31'd0, got.valid});
    cmp({name, ".fcnt"},  fetch_count, got.fc);
    cmp({name, ".scnt"},  stall_count, got.sc);
    $display("txn %-10s rst=%b pcw=%b ifw=%b br=%b pc=%h inst=%h pc4=%h v=%b fc=%0d sc=%0d",
             name, rst, pcw, ifw, br, imem_addr, IDinst, IDpc_plus_4, IDvalid,
             fetch_count, stall_count);
  endtask

  initial begin
    logic [31:0] m_pc;
    logic [31:0] m_fc;
    exp_t        e;

    checks = 0;
    errors = 0;
    reset = 1'b1; PCWrite = 1'b1; IFIDWrite = 1'b1;
    brunch_control = 1'b0; brunch_taken = 1'b0; BranchAddr = '0;

    //            name         rst pcw ifw br  baddr          pc             inst           pc4            v     fc     sc
    vecs[0]  = mk("reset",     1,  1,  1,  0,  32'h0,         32'h0,         32'h0,         32'h0,         1'b0, 32'd0, 32'd0);
    vecs[1]  = mk("first",     0,  1,  1,  0,  32'h0,         32'h4,         32'h100,       32'h4,         1'b1, 32'd1, 32'd0);
    vecs[2]  = mk("seq",       0,  1,  1,  0,  32'h0,         32'h8,         32'h104,       32'h8,         1'b1, 32'd2, 32'd0);
    vecs[3]  = mk("stall1",    0,  0,  0,  0,  32'h0,         32'h8,         32'h104,       32'h8,         1'b1, 32'd2, 32'd1);
    vecs[4]  = mk("stall2",    0,  0,  0,  0,  32'h0,         32'h8,         32'h104,       32'h8,         1'b1, 32'd2, 32'd2);
    vecs[5]  = mk("stall3",    0,  0,  0,  0,  32'h0,         32'h8,         32'h104,       32'h8,         1'b1, 32'd2, 32'd3);
    vecs[6]  = mk("resume",    0,  1,  1,  0,  32'h0,         32'hC,         32'h108,       32'hC,         1'b1, 32'd3, 32'd3);
    vecs[7]  = mk("branch",    0,  1,  1,  1,  32'h40,        32'h40,        32'h0,         32'h10,        1'b0, 32'd3, 32'd3);
    vecs[8]  = mk("target",    0,  1,  1,  0,  32'h0,         32'h44,        32'h140,       32'h44,        1'b1, 32'd4, 32'd3);
    vecs[9]  = mk("brstall",   0,  0,  0,  1,  32'h80,        32'h44,        32'h140,       32'h44,        1'b1, 32'd4, 32'd4);
    vecs[10] = mk("brretry",   0,  1,  1,  1,  32'h80,        32'h80,        32'h0,         32'h48,        1'b0, 32'd4, 32'd4);
    vecs[11] = mk("target2",   0,  1,  1,  0,  32'h0,         32'h84,        32'h180,       32'h84,        1'b1, 32'd5, 32'd4);
    vecs[12] = mk("ifidhold",  0,  1,  0,  0,  32'h0,         32'h88,        32'h180,       32'h84,        1'b1, 32'd5, 32'd4);
    vecs[13] = mk("pchold",    0,  0,  1,  0,  32'h0,         32'h88,        32'h188,       32'h8C,        1'b1, 32'd6, 32'd5);
    vecs[14] = mk("brtop",     0,  1,  1,  1,  32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0,         32'h8C,        1'b0, 32'd6, 32'd5);
    vecs[15] = mk("wrap",      0,  1,  1,  0,  32'h0,         32'h0,         32'h0000_00FC, 32'h0,         1'b1, 32'd7, 32'd5);
    vecs[16] = mk("bralign",   0,  1,  1,  1,  32'h43,        32'h40,        32'h0,         32'h4,         1'b0, 32'd7, 32'd5);
    vecs[17] = mk("rstbr",     1,  0,  0,  1,  32'h80,        32'h0,         32'h0,         32'h0,         1'b0, 32'd0, 32'd0);
    vecs[18] = mk("release",   0,  1,  1,  0,  32'h0,         32'h4,         32'h100,       32'h4,         1'b1, 32'd1, 32'd0);

    for (int i = 0; i < 19; i++) begin
      step(vecs[i].name, vecs[i].rst, vecs[i].pcw, vecs[i].ifw, vecs[i].br,
           vecs[i].baddr, vecs[i].exp);
    end

    // Straight-line run from PC=4 checked against a simple sequential model.
    m_pc = 32'h4;
    m_fc = 32'd1;
    for (int i = 0; i < 8; i++) begin
      e.pc = m_pc + 32'd4; e.inst = m_pc + 32'h100; e.pc4 = m_pc + 32'd4;
      e.valid = 1'b1; e.fc = m_fc + 32'd1; e.sc = 32'd0;
      step("run", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, e);
      m_pc = m_pc + 32'd4;
      m_fc = m_fc + 32'd1;
    end

    // Taken branch held across two stalled cycles, then honoured once released.
    e.pc = m_pc; e.inst = m_pc + 32'h100 - 32'd4; e.pc4 = m_pc; e.valid = 1'b1;
    e.fc = m_fc; e.sc = 32'd1;
    step("hold1", 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, e);
    e.sc = 32'd2;
    step("hold2", 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, e);
    e.pc = 32'h200; e.inst = 32'h0; e.pc4 = m_pc + 32'd4; e.valid = 1'b0;
    step("redir", 1'b0, 1'b1, 1'b1, 1'b1, 32'h200, e);
    e.pc = 32'h204; e.inst = 32'h300; e.pc4 = 32'h204; e.valid = 1'b1; e.fc = m_fc + 32'd1;
    step("landed", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, e);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
